// File: rtl/big_master_if.sv
// Bundle of command, response, BAR0 and BAR2 signals for the paged-window initiator.
// The master modport is the initiator's view; the slave modport is the client/bus side.
interface big_master_if #(
  parameter int BAR0_AW    = 16,
  parameter int BAR0_DW    = 64,
  parameter int BAR2_AW    = 16,
  parameter int BAR2_DW    = 64,
  parameter int PAGE_COUNT = 4,
  parameter int PAGE_SIZE  = 64
) ();
  localparam int LAW = $clog2(PAGE_COUNT * PAGE_SIZE);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [LAW-1:0]         cmd_addr;
  logic [BAR2_DW-1:0]     cmd_wdata;
  logic                   rsp_valid;
  logic [BAR2_DW-1:0]     rsp_rdata;
  logic                   rsp_err;
  logic [BAR0_AW-1:0]     bar0_address;
  logic                   bar0_write;
  logic [BAR0_DW-1:0]     bar0_writedata;
  logic [BAR0_DW/8-1:0]   bar0_byteenable;
  logic                   bar0_waitrequest;
  logic [BAR2_AW-1:0]     bar2_address;
  logic                   bar2_read;
  logic                   bar2_write;
  logic [BAR2_DW-1:0]     bar2_writedata;
  logic [BAR2_DW/8-1:0]   bar2_byteenable;
  logic                   bar2_waitrequest;
  logic                   bar2_readdatavalid;
  logic [BAR2_DW-1:0]     bar2_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output bar0_address, bar0_write, bar0_writedata, bar0_byteenable,
    input  bar0_waitrequest,
    output bar2_address, bar2_read, bar2_write, bar2_writedata, bar2_byteenable,
    input  bar2_waitrequest, bar2_readdatavalid, bar2_readdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bar0_address, bar0_write, bar0_writedata, bar0_byteenable,
    output bar0_waitrequest,
    input  bar2_address, bar2_read, bar2_write, bar2_writedata, bar2_byteenable,
    output bar2_waitrequest, bar2_readdatavalid, bar2_readdata
  );
endinterface

// File: rtl/big_master.sv
// Avalon-MM paged-window initiator: turns a linear word command into an optional BAR0
// page-select write (only on page change) followed by one BAR2 access.
module big_master #(
  parameter int BAR0_AW       = 16,
  parameter int BAR0_DW       = 64,
  parameter int BAR2_AW       = 16,
  parameter int BAR2_DW       = 64,
  parameter int PAGE_COUNT    = 4,
  parameter int PAGE_SIZE     = 64,
  parameter int PAGE_REG_ADDR = 0
) (
  input  logic         clock,
  input  logic         reset,
  big_master_if.master bus
);
  localparam int LAW = $clog2(PAGE_COUNT * PAGE_SIZE);
  localparam int OW  = $clog2(PAGE_SIZE);
  localparam int PW  = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
  localparam int BSH = $clog2(BAR2_DW / 8);

  typedef enum logic [2:0] {IDLE, SEL, ACC, RDW, RSP} state_t;

  state_t              state_q, state_d;
  logic                page_valid_q, page_valid_d;
  logic [PW-1:0]       cur_page_q, cur_page_d;
  logic                wr_q, wr_d;
  logic [PW-1:0]       page_q, page_d;
  logic [OW-1:0]       off_q, off_d;
  logic [BAR2_DW-1:0]  wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [BAR2_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [BAR0_AW-1:0]  bar0_address_q, bar0_address_d;
  logic                bar0_write_q, bar0_write_d;
  logic [BAR0_DW-1:0]  bar0_writedata_q, bar0_writedata_d;
  logic [BAR2_AW-1:0]  bar2_address_q, bar2_address_d;
  logic                bar2_read_q, bar2_read_d;
  logic                bar2_write_q, bar2_write_d;
  logic [BAR2_DW-1:0]  bar2_writedata_q, bar2_writedata_d;

  logic [LAW-1:0]      cmd_addr_s;
  logic [31:0]         cmd_page_s;
  logic [OW-1:0]       cmd_off_s;
  logic                cmd_err_s;
  logic                cmd_hit_s;
  logic                accept_s;

  assign cmd_addr_s = bus.cmd_addr;

  // Address split of the incoming command and page-hit / range decisions.
  always_comb begin
    cmd_page_s = 32'(cmd_addr_s) / 32'(PAGE_SIZE);
    cmd_off_s  = OW'(32'(cmd_addr_s) % 32'(PAGE_SIZE));
    cmd_err_s  = (cmd_page_s >= 32'(PAGE_COUNT));
    cmd_hit_s  = page_valid_q && (PW'(cmd_page_s) == cur_page_q);
    accept_s   = (state_q == IDLE) && bus.cmd_valid;
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    page_valid_d = page_valid_q;
    cur_page_d   = cur_page_q;
    wr_d         = accept_s ? bus.cmd_write  : wr_q;
    page_d       = accept_s ? PW'(cmd_page_s) : page_q;
    off_d        = accept_s ? cmd_off_s      : off_q;
    wdata_d      = accept_s ? bus.cmd_wdata  : wdata_q;
    err_d        = accept_s ? cmd_err_s      : err_q;

    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (cmd_err_s) begin
          state_d = RSP;
        end else if (cmd_hit_s) begin
          state_d = ACC;
        end else begin
          state_d = SEL;
        end
      end
      SEL: begin
        if (!bus.bar0_waitrequest) begin
          state_d      = ACC;
          cur_page_d   = page_q;
          page_valid_d = 1'b1;
        end else begin
          state_d = SEL;
        end
      end
      ACC: begin
        if (!bus.bar2_waitrequest) begin
          state_d = wr_q ? RSP : RDW;
        end else begin
          state_d = ACC;
        end
      end
      RDW: begin
        if (bus.bar2_readdatavalid) begin
          state_d = RSP;
        end else begin
          state_d = RDW;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    cmd_ready_d      = (state_d == IDLE);
    bar0_write_d     = (state_d == SEL);
    bar0_address_d   = (state_d == SEL) ? BAR0_AW'(PAGE_REG_ADDR) : {BAR0_AW{1'b0}};
    bar0_writedata_d = (state_d == SEL) ? BAR0_DW'(page_d) : bar0_writedata_q;
    bar2_write_d     = (state_d == ACC) && wr_d;
    bar2_read_d      = (state_d == ACC) && !wr_d;
    bar2_address_d   = (state_d == ACC) ? (BAR2_AW'(off_d) << BSH) : bar2_address_q;
    bar2_writedata_d = ((state_d == ACC) && wr_d) ? wdata_d : bar2_writedata_q;
    rsp_valid_d      = (state_d == RSP);
    rsp_err_d        = (state_d == RSP) && err_d;
    rsp_rdata_d      = ((state_q == RDW) && bus.bar2_readdatavalid) ? bus.bar2_readdata
                                                                     : rsp_rdata_q;
  end

  // State, captured command and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      page_valid_q     <= 1'b0;
      cur_page_q       <= {PW{1'b0}};
      wr_q             <= 1'b0;
      page_q           <= {PW{1'b0}};
      off_q            <= {OW{1'b0}};
      wdata_q          <= {BAR2_DW{1'b0}};
      err_q            <= 1'b0;
      cmd_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= {BAR2_DW{1'b0}};
      rsp_err_q        <= 1'b0;
      bar0_address_q   <= {BAR0_AW{1'b0}};
      bar0_write_q     <= 1'b0;
      bar0_writedata_q <= {BAR0_DW{1'b0}};
      bar2_address_q   <= {BAR2_AW{1'b0}};
      bar2_read_q      <= 1'b0;
      bar2_write_q     <= 1'b0;
      bar2_writedata_q <= {BAR2_DW{1'b0}};
    end else begin
      state_q          <= state_d;
      page_valid_q     <= page_valid_d;
      cur_page_q       <= cur_page_d;
      wr_q             <= wr_d;
      page_q           <= page_d;
      off_q            <= off_d;
      wdata_q          <= wdata_d;
      err_q            <= err_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
      bar0_address_q   <= bar0_address_d;
      bar0_write_q     <= bar0_write_d;
      bar0_writedata_q <= bar0_writedata_d;
      bar2_address_q   <= bar2_address_d;
      bar2_read_q      <= bar2_read_d;
      bar2_write_q     <= bar2_write_d;
      bar2_writedata_q <= bar2_writedata_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.bar0_address    = bar0_address_q;
  assign bus.bar0_write      = bar0_write_q;
  assign bus.bar0_writedata  = bar0_writedata_q;
  assign bus.bar0_byteenable = {(BAR0_DW/8){1'b1}};
  assign bus.bar2_address    = bar2_address_q;
  assign bus.bar2_read       = bar2_read_q;
  assign bus.bar2_write      = bar2_write_q;
  assign bus.bar2_writedata  = bar2_writedata_q;
  assign bus.bar2_byteenable = {(BAR2_DW/8){1'b1}};
endmodule
